alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational ALU.
- Accepts one operation per handshake; ALU ops complete in 1 cycle, an optional shift-add multiply completes in BW+1 cycles.
- Result and flags are held in an output register under valid/ready back-pressure.
- Sits between the register-file read stage and write-back in the datapath.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_seq.sv | 85 ++++++++
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the registered ALU (alu_seq)
//               and its sequential multiplier (alu_mul_seq).
//               - opcode_e : 4-bit operation select
//               - FLAG_*   : bit positions inside the 3-bit flags bus
//               - state_e  : control state of alu_seq
//               Configuration macro: ALU_MUL_EN (consumed by alu_seq).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_INC    = 4'd5,
        OP_PASS_A = 4'd6,
        OP_PASS_B = 4'd7,
        OP_MUL    = 4'd8
    } opcode_e;

    localparam int FLAG_OV   = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Unsigned shift-add multiplier, one partial product per cycle.
//               A start pulse latches the operands; BW cycles later 'done'
//               pulses for one cycle with the full 2*BW-bit product valid on
//               'product' during that same cycle.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous reset, active-high
//               start   - latch a/b and begin a multiply
//               a, b    - unsigned operands (BW bits)
//               done    - final step is being taken this cycle
//               product - running sum including this cycle's partial product
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int BW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BW-1:0]     a,
    input  logic [BW-1:0]     b,
    output logic              done,
    output logic [2*BW-1:0]   product
);

    localparam int CW = $clog2(BW);

    logic [2*BW-1:0] mcand_q, mcand_d;
    logic [2*BW-1:0] acc_q,   acc_d;
    logic [BW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            run_q,   run_d;
    logic [2*BW-1:0] sum;

    // The product is taken from the adder output so the top can load it on the
    // same edge that retires the last step.
    always_comb begin
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done     = 1'b0;
        if (start) begin
            mcand_d  = {{BW{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(BW - 1)) begin
                done  = 1'b1;
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    assign product = sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready handshakes on both sides.
//               Single-cycle ALU ops; optional BW-cycle shift-add multiply.
//               Result and flags sit in an output register that holds under
//               back-pressure.
// Ports       : clk, rst            - clock (rising) / async reset (active-high)
//               in_valid / in_ready - operation handshake
//               in_a, in_b, opcode  - operands and operation select
//               out_valid/out_ready - result handshake
//               out, flags          - result, {overflow, negative, zero}
//               busy                - multiply in progress
// Config      : ALU_MUL_EN - when defined, opcode 8 runs the sequential
//               multiplier; otherwise opcode 8 is an unused opcode and busy
//               is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_a,
    input  logic [BW-1:0] in_b,
    input  logic [3:0]    opcode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out,
    output logic [2:0]    flags,
    output logic          busy
);

    function automatic logic [2:0] make_flags(input logic [BW-1:0] res, input logic ov);
        logic [2:0] f;
        f            = '0;
        f[FLAG_OV]   = ov;
        f[FLAG_NEG]  = res[BW-1];
        f[FLAG_ZERO] = (res == '0);
        return f;
    endfunction

    logic [BW-1:0] out_q, out_d;
    logic [2:0]    flags_q, flags_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] alu_res;
    logic          alu_ov;
    logic          accept;
    logic          is_mul;
    logic          out_free;

    // Output register can take a new value if empty or being drained now.
    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Single-cycle operations; opcode 8 (and 9-15) fall to the zero default.
    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD: begin
                alu_res = in_a + in_b;
                alu_ov  = (in_a[BW-1] == in_b[BW-1]) && (alu_res[BW-1] != in_a[BW-1]);
            end
            OP_SUB: begin
                alu_res = in_a - in_b;
                alu_ov  = (in_a[BW-1] != in_b[BW-1]) && (alu_res[BW-1] != in_a[BW-1]);
            end
            OP_AND:    alu_res = in_a & in_b;
            OP_OR:     alu_res = in_a | in_b;
            OP_XOR:    alu_res = in_a ^ in_b;
            OP_INC: begin
                alu_res = in_a + BW'(1);
                // +1 is positive, so only a positive a can overflow.
                alu_ov  = !in_a[BW-1] && alu_res[BW-1];
            end
            OP_PASS_A: alu_res = in_a;
            OP_PASS_B: alu_res = in_b;
            default: begin
                alu_res = '0;
                alu_ov  = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            mul_done;
    logic [2*BW-1:0] mul_product;

    assign is_mul   = (opcode == OP_MUL);
    assign in_ready = (state_q == ST_IDLE) && out_free;
    assign busy     = busy_q;

    alu_mul_seq #(
        .BW (BW)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul   = 1'b0;
    assign in_ready = out_free;
    assign busy     = 1'b0;
`endif

    always_comb begin
        out_d       = out_q;
        flags_d     = flags_q;
        // A drained result clears valid; data stays as the last value.
        out_valid_d = out_valid_q && !out_ready;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        busy_d      = busy_q;
`endif
        if (accept && !is_mul) begin
            out_d       = alu_res;
            flags_d     = make_flags(alu_res, alu_ov);
            out_valid_d = 1'b1;
        end
`ifdef ALU_MUL_EN
        if (accept && is_mul) begin
            state_d = ST_MUL;
            busy_d  = 1'b1;
        end
        if ((state_q == ST_MUL) && mul_done) begin
            out_d       = mul_product[BW-1:0];
            flags_d     = make_flags(mul_product[BW-1:0], |mul_product[2*BW-1:BW]);
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
`endif
        end else begin
            out_q       <= out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            state_q     <= state_d;
            busy_q      <= busy_d;
`endif
        end
    end

    assign out       = out_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (BW=16). A transaction-level
//               reference model predicts out/flags/out_valid/busy/in_ready
//               every cycle; directed vectors add hand-computed literal checks.
//               Honours ALU_MUL_EN for the multiply tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int BW = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint SMAX = (longint'(1) << (BW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (BW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic [3:0]    opcode = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out;
    logic [2:0]    flags;
    logic          busy;

    int n_tot = 0;
    int n_bad = 0;

    alu_seq #(.BW(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference result: {ov, neg, zero, result} from signed/unsigned integer math.
    function automatic logic [BW+2:0] ref_op(input logic [3:0] op,
                                             input logic [BW-1:0] a,
                                             input logic [BW-1:0] b);
        longint          sa, sb, full;
        longint unsigned prod;
        logic [BW-1:0]   r;
        logic            ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        ov = 1'b0;
        case (op)
            4'd0: begin full = sa + sb; ov = (full > SMAX) || (full < SMIN); r = BW'(full); end
            4'd1: begin full = sa - sb; ov = (full > SMAX) || (full < SMIN); r = BW'(full); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin full = sa + 1; ov = (full > SMAX); r = BW'(full); end
            4'd6: r = a;
            4'd7: r = b;
            4'd8: begin
                if (MUL_EN) begin
                    prod = longint'(a) * longint'(b);
                    ov   = (prod >> BW) != 0;
                    r    = BW'(prod);
                end
            end
            default: r = '0;
        endcase
        return {ov, r[BW-1], (r == '0), r};
    endfunction

    // Model state
    logic [BW-1:0] m_out = '0;
    logic [2:0]    m_flags = '0;
    logic          m_valid = 1'b0;
    int            m_left = 0;
    logic [BW+2:0] m_pend = '0;
    logic          m_in_ready;

    assign m_in_ready = (m_left == 0) && (!m_valid || out_ready);

    always @(posedge clk or posedge rst) begin
        logic          got_res;
        logic [BW+2:0] res;
        got_res = 1'b0;
        res     = '0;
        if (rst) begin
            m_out   = '0;
            m_flags = '0;
            m_valid = 1'b0;
            m_left  = 0;
        end else begin
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    got_res = 1'b1;
                    res     = m_pend;
                end
            end else if (in_valid && m_in_ready) begin
                if (MUL_EN && opcode == 4'd8) begin
                    m_left = BW;
                    m_pend = ref_op(opcode, in_a, in_b);
                end else begin
                    got_res = 1'b1;
                    res     = ref_op(opcode, in_a, in_b);
                end
            end
            if (got_res) begin
                m_out   = res[BW-1:0];
                m_flags = res[BW+2:BW];
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        n_tot++;
        if ({out, flags, out_valid, busy, in_ready} !==
            {m_out, m_flags, m_valid, (m_left != 0), m_in_ready}) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t got out=%h flags=%b v=%b busy=%b rdy=%b want out=%h flags=%b v=%b busy=%b rdy=%b",
                     $time, out, flags, out_valid, busy, in_ready,
                     m_out, m_flags, m_valid, (m_left != 0), m_in_ready);
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
        in_valid = 1'b1;
        opcode   = op;
        in_a     = a;
        in_b     = b;
    endtask

    // Directed table: opcode, a, b, expected {out, flags}
    logic [3:0]    t_op  [8] = '{4'd2, 4'd3, 4'd6, 4'd7, 4'd1, 4'd12, 4'd0, 4'd5};
    logic [BW-1:0] t_a   [8] = '{16'hF0F0, 16'h0F00, 16'h8000, 16'h1234, 16'h8000, 16'h1111, 16'h8000, 16'h7FFF};
    logic [BW-1:0] t_b   [8] = '{16'hFF00, 16'h00F0, 16'h1234, 16'h0000, 16'h0001, 16'h2222, 16'h8000, 16'h0000};
    logic [BW+2:0] t_exp [8] = '{{16'hF000, 3'b010}, {16'h0FF0, 3'b000}, {16'h8000, 3'b010},
                                 {16'h0000, 3'b001}, {16'h7FFF, 3'b100}, {16'h0000, 3'b001},
                                 {16'h0000, 3'b101}, {16'h8000, 3'b110}};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the reference model to hand-computed values.
        lit("model_add", 32'(ref_op(4'd0, 16'h7FFF, 16'h0001)), 32'({3'b110, 16'h8000}));
        lit("model_sub", 32'(ref_op(4'd1, 16'h8000, 16'h0001)), 32'({3'b100, 16'h7FFF}));
        lit("model_mul", 32'(ref_op(4'd8, 16'd300, 16'd300)),
            MUL_EN ? 32'({3'b100, 16'h5F90}) : 32'({3'b001, 16'h0000}));

        repeat (3) step();
        @(negedge clk);
        lit("reset_state", 32'({out, flags, out_valid, busy}), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        lit("ready_after_reset", 32'(in_ready), 32'h1);

        // ADD overflow into sign bit
        step();
        drive(4'd0, 16'h7FFF, 16'h0001);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        lit("add_result", 32'({out, flags, out_valid}), 32'({16'h8000, 3'b110, 1'b1}));
        step();
        @(negedge clk);
        lit("add_valid_one_cycle", 32'(out_valid), 32'h0);

        // SUB then INC back-to-back
        step();
        drive(4'd1, 16'd5, 16'd5);
        step();
        drive(4'd5, 16'hFFFF, 16'h0000);
        @(negedge clk);
        lit("sub_result", 32'({out, flags, out_valid}), 32'({16'h0000, 3'b001, 1'b1}));
        lit("b2b_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        lit("inc_result", 32'({out, flags, out_valid}), 32'({16'h0000, 3'b001, 1'b1}));

        // Directed table
        for (int i = 0; i < 8; i++) begin
            step();
            drive(t_op[i], t_a[i], t_b[i]);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            lit($sformatf("table_%0d", i), 32'({out, flags}), 32'(t_exp[i]));
        end

        // Back-pressure hold
        step();
        out_ready = 1'b0;
        drive(4'd4, 16'h00FF, 16'h0F0F);
        step();
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            lit("bp_hold", 32'({out, flags, out_valid, in_ready}), 32'({16'h0FF0, 3'b000, 1'b1, 1'b0}));
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        lit("bp_release_valid", 32'({out_valid, in_ready}), 32'b11);
        step();
        @(negedge clk);
        lit("bp_drained", 32'(out_valid), 32'h0);

`ifdef ALU_MUL_EN
        // Sequential multiply
        step();
        drive(4'd8, 16'd300, 16'd300);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < BW; i++) begin
            @(negedge clk);
            lit("mul_busy", 32'({busy, in_ready, out_valid}), 32'b100);
            step();
        end
        @(negedge clk);
        lit("mul_result", 32'({out, flags, out_valid, busy}), 32'({16'h5F90, 3'b100, 1'b1, 1'b0}));

        // Reset mid-multiply
        step();
        drive(4'd8, 16'd300, 16'd300);
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        #1;
        lit("rst_mid_mul", 32'({out, flags, out_valid, busy}), 32'h0);
`else
        // Opcode 8 without multiplier
        step();
        drive(4'd8, 16'd3, 16'd4);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        lit("op8_unused", 32'({out, flags, out_valid, busy}), 32'({16'h0000, 3'b001, 1'b1, 1'b0}));

        // Reset while a result is held
        step();
        out_ready = 1'b0;
        drive(4'd0, 16'd1, 16'd2);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        lit("rst_held", 32'({out, flags, out_valid, busy}), 32'h0);
        out_ready = 1'b1;
`endif
        step();
        rst = 1'b0;
        @(negedge clk);
        lit("ready_after_rst2", 32'(in_ready), 32'h1);
        step();
        drive(4'd0, 16'd2, 16'd3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        lit("add_after_rst", 32'({out, flags, out_valid}), 32'({16'h0005, 3'b000, 1'b1}));
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
